mac_job_sched: RTL and testbench
================================

Name: mac_job_sched

Overview:
- Round-robin job scheduler that shares one mac_core instance among NUM_REQ requesters.
- Per job: grants one requester, snapshots the MAC accumulator baseline, streams that requester's words into the MAC, reads the final value and returns the job sum (final − baseline, mod 2^16) on a valid/ready result port.
- Needed because mac_core has no clear input; the baseline subtraction gives per-job sums.
- Sits between the requester fabric and the mac_core port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- LEN_W, 8, width of the job length field; maximum job length 2^LEN_W − 1 words
- DATA_W, 16, word width; must match the mac_core data width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- job_req  in  NUM_REQ  per-requester job request level
- job_len  in  NUM_REQ*LEN_W  packed job lengths; slice i belongs to requester i
- job_ack  out  NUM_REQ  one-hot, one-cycle grant pulse
- in_valid  in  NUM_REQ  per-requester data valid
- in_data  in  NUM_REQ*DATA_W  packed data words
- in_ready  out  NUM_REQ  one-hot ready, granted requester only, STREAM state only
- res_valid  out  1  result valid
- res_data  out  DATA_W  job sum mod 2^DATA_W
- res_id  out  $clog2(NUM_REQ)  requester index of the result
- res_ready  in  1  result consumer ready
- busy  out  1  high in every state except IDLE
- mac_chip_sel  out  1  to mac_core chip_sel
- mac_wr_en  out  1  to mac_core wr_en
- mac_rd_en  out  1  to mac_core rd_en
- mac_data  out  DATA_W  to mac_core data_in
- mac_data_out  in  DATA_W  from mac_core data_out
- mac_output_ready  in  1  from mac_core output_ready

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All outputs go to 0; state = IDLE; round-robin pointer = 0; base, len_cnt, grant registers = 0.
- Reset mid-job aborts the job with no result. The MAC accumulator is not cleared by this block; the baseline mechanism tolerates this.
- FSM states: IDLE, BASE_RD, BASE_WAIT, STREAM, FIN_RD, FIN_WAIT, RESP.
- IDLE: if any job_req is high, pick the first requester at or after the pointer, wrapping modulo NUM_REQ.
  - Pulse job_ack[g] for that cycle.
  - Latch g and job_len[g]; pointer <= (g+1) mod NUM_REQ.
  - Go to BASE_RD.
- BASE_RD: mac_chip_sel=1, mac_rd_en=1 for exactly one cycle -> BASE_WAIT.
- BASE_WAIT: mac_chip_sel=1, rd_en=0. On mac_output_ready, base <= mac_data_out. Then go to STREAM, or to FIN_RD if len=0.
- STREAM: mac_chip_sel=1, in_ready[g]=1, mac_data=in_data[g].
  - mac_wr_en = in_valid[g] (combinational).
  - Each accepted word decrements len_cnt; the word that brings len_cnt to 0 moves the FSM to FIN_RD.
  - Throughput is 1 word/cycle; in_valid gaps stall the FSM with no timeout.
- FIN_RD: mac_chip_sel=1, mac_rd_en=1 for one cycle, wr_en=0 -> FIN_WAIT. Never assert wr_en and rd_en together.
- FIN_WAIT: on mac_output_ready, res_data <= mac_data_out − base (mod 2^DATA_W), res_id <= g, res_valid <= 1 -> RESP.
- RESP: hold res_valid, res_data and res_id stable until res_valid && res_ready, then res_valid <= 0 -> IDLE.
- Arbitration latency: a new grant is possible the cycle after RESP completes.
- Latency (len=N, no stalls): job_ack cycle + 1 BASE_RD + 1 BASE_WAIT + N STREAM + 1 FIN_RD + 1 FIN_WAIT, so res_valid rises N+5 cycles after job_ack.
- job_req is sampled only in IDLE; requests held during a job wait their turn.
- job_len changes after job_ack are ignored.
- mac_chip_sel=0 in IDLE and RESP.

Decomposition:
- Package mac_pkg: DATA_W default, the state enum type for IDLE..RESP, and a function for the index width.
- One sub-module, rr_arbiter (NUM_REQ): request vector + pointer in, one-hot grant + index + any_grant out, purely combinational.

Test Plan:
- Single requester: req0, len=3, words 5,7,9, fresh reset -> res_data=21, res_id=0, res_valid 8 cycles after job_ack.
- Non-zero baseline: run a job summing 100, then a job 1,2,3 -> second res_data=6, proving baseline subtraction.
- Wrap-around: baseline 0xFFF0, words 0x0020 -> res_data=0x0020 despite the 16-bit accumulator wrap.
- Round-robin: req0..3 all held high continuously, len=1 each -> job_ack order 0,1,2,3,0; no requester is granted twice in a row.
- Backpressure and stalls: in_valid toggling every other cycle plus res_ready low for 5 cycles -> exact sum, res_data and res_id stable while stalled, no extra mac_wr_en pulses.
- len=0 and reset: len=0 -> res_data=0 with mac_wr_en never asserted; reset_n asserted mid-STREAM -> all outputs 0 immediately, next job result correct.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC job scheduler.
//   MAC_DATA_W    default word width of the mac_core data path
//   sched_state_e scheduler FSM states
//   idx_width()   width of a requester index for a given requester count
package mac_pkg;

    localparam int unsigned MAC_DATA_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StBaseRd,
        StBaseWait,
        StStream,
        StFinRd,
        StFinWait,
        StResp
    } sched_state_e;

    // Never returns 0 so a single-requester build still has a legal index port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        per-requester request level
//   ptr        index of the highest-priority requester this round
//   grant      one-hot grant (first requester at or after ptr, wrapping)
//   grant_idx  binary index of the granted requester
//   any_grant  high when some requester is granted
module rr_arbiter
    import mac_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    int unsigned     cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        // Walk the ring starting at ptr; the first requester found wins.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(ptr) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any_grant && req[cand_idx]) begin
                any_grant = 1'b1;
                grant_idx = cand_idx;
                grant     = NUM_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/mac_job_sched.sv
// Round-robin job scheduler sharing one mac_core among NUM_REQ requesters.
// Each job reads the accumulator as a baseline, streams the granted requester's
// words into the MAC, reads the final accumulator and returns final - baseline.
//   clk, reset_n        clock, asynchronous active-low reset
//   job_req/job_len     per-requester job request and packed job length
//   job_ack             one-hot, one-cycle grant pulse
//   in_valid/in_data    per-requester word stream; in_ready one-hot for the grantee
//   res_*               job result (valid/ready), sum mod 2^DATA_W and requester id
//   busy                high whenever a job is in progress
//   mac_*               mac_core port (chip_sel, wr_en, rd_en, data_in, data_out,
//                       output_ready)
module mac_job_sched
    import mac_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned DATA_W  = MAC_DATA_W,
    localparam int unsigned ID_W   = idx_width(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          job_req,
    input  logic [NUM_REQ*LEN_W-1:0]    job_len,
    output logic [NUM_REQ-1:0]          job_ack,
    input  logic [NUM_REQ-1:0]          in_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   in_data,
    output logic [NUM_REQ-1:0]          in_ready,
    output logic                        res_valid,
    output logic [DATA_W-1:0]           res_data,
    output logic [ID_W-1:0]             res_id,
    input  logic                        res_ready,
    output logic                        busy,
    output logic                        mac_chip_sel,
    output logic                        mac_wr_en,
    output logic                        mac_rd_en,
    output logic [DATA_W-1:0]           mac_data,
    input  logic [DATA_W-1:0]           mac_data_out,
    input  logic                        mac_output_ready
);

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   gnt_q, gnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic              res_valid_q, res_valid_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;

    logic [LEN_W-1:0]   req_len;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (job_req),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // Length of the requester being granted now, data of the requester already granted.
    always_comb begin
        req_len  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == ID_W'(i)) begin
                req_len = job_len[i*LEN_W +: LEN_W];
            end
            if (gnt_q == ID_W'(i)) begin
                sel_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_valid = in_valid[gnt_q];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        len_d        = len_q;
        base_d       = base_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        job_ack      = '0;
        in_ready     = '0;
        mac_chip_sel = 1'b0;
        mac_wr_en    = 1'b0;
        mac_rd_en    = 1'b0;
        mac_data     = '0;

        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    // The grant pulse is combinational; keep it quiet while in reset.
                    job_ack = reset_n ? arb_grant : '0;
                    gnt_d   = arb_idx;
                    len_d   = req_len;
                    ptr_d   = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d = StBaseRd;
                end
            end
            StBaseRd: begin
                mac_chip_sel = 1'b1;
                mac_rd_en    = 1'b1;
                state_d      = StBaseWait;
            end
            StBaseWait: begin
                mac_chip_sel = 1'b1;
                if (mac_output_ready) begin
                    base_d  = mac_data_out;
                    state_d = (len_q == '0) ? StFinRd : StStream;
                end
            end
            StStream: begin
                mac_chip_sel    = 1'b1;
                in_ready[gnt_q] = 1'b1;
                mac_data        = sel_data;
                mac_wr_en       = sel_valid;
                if (sel_valid) begin
                    len_d = len_q - 1'b1;
                    if (len_q == LEN_W'(1)) begin
                        state_d = StFinRd;
                    end
                end
            end
            StFinRd: begin
                mac_chip_sel = 1'b1;
                mac_rd_en    = 1'b1;
                state_d      = StFinWait;
            end
            StFinWait: begin
                mac_chip_sel = 1'b1;
                if (mac_output_ready) begin
                    // Accumulator is never cleared, so the job sum is relative to the baseline.
                    res_data_d  = mac_data_out - base_q;
                    res_id_d    = gnt_q;
                    res_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            gnt_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mac_job_sched.sv
// Bench for mac_job_sched: accumulator model of mac_core, per-requester word
// queues, and a per-cycle scoreboard predicting grants and job sums.
module tb_mac_job_sched;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 8;
    localparam int DATA_W  = 16;

    logic                      clk;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        job_req;
    logic [NUM_REQ*LEN_W-1:0]  job_len;
    logic [NUM_REQ-1:0]        job_ack;
    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        in_ready;
    logic                      res_valid;
    logic [DATA_W-1:0]         res_data;
    logic [1:0]                res_id;
    logic                      res_ready;
    logic                      busy;
    logic                      mac_chip_sel;
    logic                      mac_wr_en;
    logic                      mac_rd_en;
    logic [DATA_W-1:0]         mac_data;
    logic [DATA_W-1:0]         mac_data_out;
    logic                      mac_output_ready;

    mac_job_sched #(
        .NUM_REQ (NUM_REQ),
        .LEN_W   (LEN_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .job_req          (job_req),
        .job_len          (job_len),
        .job_ack          (job_ack),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .res_valid        (res_valid),
        .res_data         (res_data),
        .res_id           (res_id),
        .res_ready        (res_ready),
        .busy             (busy),
        .mac_chip_sel     (mac_chip_sel),
        .mac_wr_en        (mac_wr_en),
        .mac_rd_en        (mac_rd_en),
        .mac_data         (mac_data),
        .mac_data_out     (mac_data_out),
        .mac_output_ready (mac_output_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mac_core model: accumulating adder, read returns the sum one cycle later.
    logic [DATA_W-1:0] acc;
    logic              acc_load;
    logic [DATA_W-1:0] acc_load_val;
    always @(posedge clk) begin
        mac_output_ready <= 1'b0;
        if (acc_load) acc <= acc_load_val;
        else if (mac_chip_sel && mac_wr_en) acc <= acc + mac_data;
        if (mac_chip_sel && mac_rd_en) begin
            mac_output_ready <= 1'b1;
            mac_data_out     <= acc;
        end
    end

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] word_q [NUM_REQ][$];
    int len_q     [NUM_REQ][$];
    int exp_sum_q [NUM_REQ][$];
    int exp_id_q[$];
    int exp_len_q[$];
    int ack_order[$];
    int res_log_data[$];
    int res_log_id[$];
    int lat_log[$];
    int model_ptr = 0;
    int wr_cnt    = 0;
    int ack_cyc   = 0;
    bit prev_rv   = 0;
    bit gap_mode  = 0;
    bit stall_mode = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_job(input int r, input int n, input int w0, input int step);
        int s;
        logic [DATA_W-1:0] w;
        s = 0;
        for (int k = 0; k < n; k++) begin
            w = 16'(w0 + k * step);
            word_q[r].push_back(w);
            s += int'(w);
        end
        exp_sum_q[r].push_back(s & 'hFFFF);
        len_q[r].push_back(n);
    endtask

    function automatic bit pending();
        for (int i = 0; i < NUM_REQ; i++) if (len_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((pending() || busy || exp_id_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 3000) check(name, 0, 1);
    endtask

    task automatic check_last(input string name, input int exp_data, input int exp_id);
        if (res_log_data.size() == 0) begin
            check({name, "_present"}, 0, 1);
        end else begin
            check({name, "_data"}, res_log_data[$], exp_data);
            check({name, "_id"}, res_log_id[$], exp_id);
        end
    endtask

    // Scoreboard on the falling edge, stimulus update just after the rising edge.
    task automatic monitor_and_feed();
        logic [NUM_REQ-1:0] pop_w, pop_l;
        int g, c, id;
        forever begin
            @(negedge clk);
            pop_w = '0;
            pop_l = '0;
            if (!reset_n) begin
                model_ptr = 0;
                prev_rv   = 0;
            end else begin
                check("wr_rd_excl", int'(mac_wr_en & mac_rd_en), 0);
                if (mac_wr_en) wr_cnt++;
                for (int i = 0; i < NUM_REQ; i++) pop_w[i] = in_valid[i] & in_ready[i];
                if (job_ack != '0) begin
                    g = -1;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        c = (model_ptr + k) % NUM_REQ;
                        if (g < 0 && job_req[c]) g = c;
                    end
                    if (g < 0) begin
                        check("ack_unexpected", int'(job_ack), 0);
                    end else begin
                        check("ack_grant", int'(job_ack), 1 << g);
                        model_ptr = (g + 1) % NUM_REQ;
                        exp_id_q.push_back(g);
                        exp_len_q.push_back(len_q[g].size() != 0 ? len_q[g][0] : 0);
                        ack_order.push_back(g);
                        ack_cyc  = cyc;
                        wr_cnt   = 0;
                        pop_l[g] = 1'b1;
                    end
                end
                if (res_valid) begin
                    if (exp_id_q.size() == 0) begin
                        check("res_spurious", 1, 0);
                    end else begin
                        id = exp_id_q[0];
                        check("res_id", int'(res_id), id);
                        if (exp_sum_q[id].size() == 0) check("res_sum_known", 0, 1);
                        else check("res_data", int'(res_data), exp_sum_q[id][0]);
                        if (!prev_rv) begin
                            lat_log.push_back(cyc - ack_cyc);
                            if (!stall_mode) check("latency", cyc - ack_cyc, exp_len_q[0] + 5);
                            check("wr_count", wr_cnt, exp_len_q[0]);
                        end
                        if (res_ready) begin
                            res_log_data.push_back(int'(res_data));
                            res_log_id.push_back(int'(res_id));
                            void'(exp_id_q.pop_front());
                            void'(exp_len_q.pop_front());
                            if (exp_sum_q[id].size() != 0) void'(exp_sum_q[id].pop_front());
                        end
                    end
                end
                prev_rv = res_valid;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pop_w[i] && word_q[i].size() != 0) void'(word_q[i].pop_front());
                if (pop_l[i] && len_q[i].size() != 0) void'(len_q[i].pop_front());
                in_valid[i] = (word_q[i].size() != 0) && !(gap_mode && cyc[0]);
                in_data[i*DATA_W +: DATA_W] = (word_q[i].size() != 0) ? word_q[i][0] : '0;
                job_req[i] = (len_q[i].size() != 0);
                job_len[i*LEN_W +: LEN_W] = (len_q[i].size() != 0) ? LEN_W'(len_q[i][0]) : '0;
            end
        end
    endtask

    int exp_rr[5];
    int n;

    initial begin
        reset_n      = 1'b0;
        res_ready    = 1'b1;
        acc_load     = 1'b1;
        acc_load_val = '0;
        job_req      = '0;
        job_len      = '0;
        in_valid     = '0;
        in_data      = '0;
        fork
            monitor_and_feed();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_job_ack", int'(job_ack), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_data", int'(res_data), 0);
        check("rst_res_id", int'(res_id), 0);
        check("rst_mac_ctl", int'({mac_chip_sel, mac_wr_en, mac_rd_en}), 0);
        check("rst_mac_data", int'(mac_data), 0);
        @(posedge clk);
        #2;
        acc_load = 1'b0;
        reset_n  = 1'b1;

        // Single job from a zero accumulator: 5+7+9.
        add_job(0, 3, 5, 2);
        wait_done("t1_timeout");
        check_last("t1", 21, 0);
        if (lat_log.size() != 0) check("t1_latency", lat_log[$], 8);
        else check("t1_latency_present", 0, 1);

        // Baseline subtraction: second job starts from accumulator 121.
        add_job(1, 1, 100, 0);
        wait_done("t2a_timeout");
        check_last("t2a", 100, 1);
        add_job(2, 3, 1, 1);
        wait_done("t2b_timeout");
        check_last("t2b", 6, 2);

        // Accumulator wrap: baseline 0xFFF0 plus 0x20.
        @(posedge clk);
        #2;
        acc_load     = 1'b1;
        acc_load_val = 16'hFFF0;
        @(posedge clk);
        #2;
        acc_load = 1'b0;
        add_job(3, 1, 32, 0);
        wait_done("t3_timeout");
        check_last("t3", 32, 3);

        // Round robin with every requester asking at once.
        ack_order.delete();
        add_job(0, 1, 1, 0);
        add_job(1, 1, 11, 0);
        add_job(2, 1, 21, 0);
        add_job(3, 1, 31, 0);
        add_job(0, 1, 41, 0);
        wait_done("rr_timeout");
        exp_rr = '{0, 1, 2, 3, 0};
        check("rr_count", ack_order.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < ack_order.size()) check($sformatf("rr_order%0d", k), ack_order[k], exp_rr[k]);
        end
        check_last("rr_last", 41, 0);

        // Input gaps plus result backpressure.
        stall_mode = 1'b1;
        gap_mode   = 1'b1;
        res_ready  = 1'b0;
        add_job(2, 4, 10, 10);
        n = 0;
        while (!res_valid && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("bp_res_seen", int'(res_valid), 1);
        repeat (5) begin
            @(posedge clk);
            #2;
            check("bp_hold_valid", int'(res_valid), 1);
            check("bp_hold_data", int'(res_data), 100);
            check("bp_hold_id", int'(res_id), 2);
        end
        res_ready = 1'b1;
        wait_done("bp_timeout");
        check_last("bp", 100, 2);
        gap_mode   = 1'b0;
        stall_mode = 1'b0;

        // Zero-length job.
        add_job(1, 0, 0, 0);
        wait_done("len0_timeout");
        check_last("len0", 0, 1);

        // Reset in the middle of a stream, then a clean job.
        gap_mode = 1'b1;
        add_job(3, 6, 1, 1);
        n = 0;
        while (!in_ready[3] && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("mid_stream_reached", int'(in_ready[3]), 1);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_mac_ctl", int'({mac_chip_sel, mac_wr_en, mac_rd_en}), 0);
        check("mid_rst_res_valid", int'(res_valid), 0);
        check("mid_rst_job_ack", int'(job_ack), 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            word_q[i].delete();
            len_q[i].delete();
            exp_sum_q[i].delete();
        end
        exp_id_q.delete();
        exp_len_q.delete();
        gap_mode = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        add_job(0, 2, 7, 1);
        wait_done("post_rst_timeout");
        check_last("post_rst", 15, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
